uart_cmd_link: RTL and testbench
================================

// Module: uart_cmd_link
// PURPOSE
//  Byte-level link between UART rx/tx cores and cmd_cfg. Assembles two received bytes (high first)
//  into a 16-bit command, holds it with cmd_rdy until cmd_cfg pulses clr_cmd_rdy, latches cmd_cfg's
//  single-cycle resp/send_resp into a 1-deep-queued tx path, returns resp_sent per transmitted byte.
// PARAMETERS
//  TIMEOUT_CYC  1_000_000  clk cycles allowed between high and low cmd byte before resync
//  TO_W         20         width of inter-byte timeout counter (2**TO_W > TIMEOUT_CYC)
// PORTS
//  clk          in   1   system clock
//  rst          in   1   reset, synchronous, active-high
//  rx_rdy       in   1   UART rx core holds a received byte (level until cleared)
//  rx_data      in   8   received byte
//  clr_rx_rdy   out  1   one-cycle pulse: byte consumed
//  cmd          out  16  assembled command {hi,lo}
//  cmd_rdy      out  1   cmd valid, held until clr_cmd_rdy
//  clr_cmd_rdy  in   1   cmd_cfg done with cmd
//  resp         in   8   response byte, valid only in send_resp cycle
//  send_resp    in   1   one-cycle request to transmit resp
//  resp_sent    out  1   one-cycle pulse: a response byte finished transmitting
//  trmt         out  1   one-cycle pulse to UART tx core: start byte
//  tx_data      out  8   byte to transmit, stable from trmt until tx_done
//  tx_done      in   1   one-cycle pulse from tx core: byte finished
//  frame_err    out  1   one-cycle pulse: high byte discarded on timeout
//  tx_ovr       out  1   sticky: send_resp dropped (queue full); cleared only by rst
// BEHAVIOUR
//  Reset: all outputs 0, cmd=16'h0000, rx FSM WAIT_HI, tx FSM TX_IDLE, queue empty, timer 0.
//  RX FSM (rx_state_t: WAIT_HI, WAIT_LO, HOLD):
//   WAIT_HI: rx_rdy -> cmd[15:8]<=rx_data, clr_rx_rdy pulse, timer<=0, ->WAIT_LO.
//   WAIT_LO: rx_rdy -> cmd[7:0]<=rx_data, clr_rx_rdy pulse, ->HOLD; cmd_rdy=1 from next cycle.
//    else timer++; timer==TIMEOUT_CYC-1 -> frame_err pulse, ->WAIT_HI (cmd unchanged, cmd_rdy 0).
//    rx_rdy wins over timeout in the same cycle.
//   HOLD: cmd, cmd_rdy=1 stable; rx_rdy NOT consumed (byte stays pending in rx core).
//    clr_cmd_rdy -> cmd_rdy=0 next cycle, ->WAIT_HI; pending byte taken the cycle after.
//   clr_rx_rdy asserted at most once per byte; never in HOLD. clr_cmd_rdy outside HOLD ignored.
//  TX FSM (tx_state_t: TX_IDLE, TX_BUSY), pending reg pend_data/pend_vld:
//   TX_IDLE: send_resp at cycle N -> tx_data<=resp, trmt=1 at N+1, ->TX_BUSY.
//   TX_BUSY: send_resp & !pend_vld -> pend_data<=resp, pend_vld<=1.
//    send_resp & pend_vld -> byte dropped, tx_ovr<=1.
//    tx_done at cycle M -> resp_sent=1 at M+1; if pend_vld: tx_data<=pend_data, trmt=1 at M+1,
//    pend_vld<=0, stay TX_BUSY; else ->TX_IDLE.
//   send_resp coincident with tx_done (pend empty): resp goes to tx_data, trmt at M+1 (no queueing).
//   tx_done in TX_IDLE ignored (no resp_sent).
//  trmt, resp_sent, clr_rx_rdy, frame_err registered (all outputs are flop outputs).
//  rst mid-operation: partial command, pending byte, in-flight byte abandoned; no resp_sent.
//  RX and TX paths independent; cmd_cfg is responsible for not reusing cmd before clr_cmd_rdy.
// STRUCTURE
//  link_pkg: rx_state_t, tx_state_t enums; ACK=8'hA5, NAK=8'hEE (shared with cmd_cfg/bench).
//  One sub-module natural: resp_tx_q (TX FSM + pending reg, ~100 lines); RX FSM + timer inline.
// TESTING
//  1 rx 8'h47 then 8'h12 -> one clr_rx_rdy each; cmd=16'h4712, cmd_rdy 1 until clr_cmd_rdy, 0 next.
//  2 rx 8'h40, no 2nd byte for TIMEOUT_CYC -> frame_err pulse once; next 8'h01,8'h02 -> cmd=16'h0102.
//  3 byte arrives in HOLD -> no clr_rx_rdy until clr_cmd_rdy; then consumed as new high byte.
//  4 send_resp resp=8'hA5 -> trmt next cycle, tx_data=8'hA5; tx_done -> single resp_sent next cycle.
//  5 busy; send_resp 8'h11, then 8'h22 -> 8'h11 queued, 8'h22 dropped, tx_ovr=1; 2 resp_sent total.
//  6 rst asserted with cmd_rdy=1 and pend_vld=1 -> all outputs 0 next cycle, no trmt after release.

Source files
------------

// File: rtl/link_pkg.sv
// Shared types and response codes for the UART command link and its cmd_cfg peer.
package link_pkg;

  typedef enum logic [1:0] {
    WAIT_HI = 2'd0,
    WAIT_LO = 2'd1,
    HOLD    = 2'd2
  } rx_state_t;

  typedef enum logic {
    TX_IDLE = 1'b0,
    TX_BUSY = 1'b1
  } tx_state_t;

  localparam logic [7:0] ACK = 8'hA5;
  localparam logic [7:0] NAK = 8'hEE;

endpackage

// File: rtl/uart_cmd_link_resp_tx_q.sv
// Response transmit path: one byte in flight plus one pending; trmt/resp_sent one cycle after the cause.
// A send_resp arriving with both slots occupied is dropped and flagged in sticky tx_ovr.
module resp_tx_q
  import link_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       send_resp,
  input  logic [7:0] resp,
  input  logic       tx_done,
  output logic       trmt,
  output logic [7:0] tx_data,
  output logic       resp_sent,
  output logic       tx_ovr
);

  tx_state_t  state_q, state_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic [7:0] pend_data_q, pend_data_d;
  logic       pend_vld_q, pend_vld_d;
  logic       trmt_q, trmt_d;
  logic       resp_sent_q, resp_sent_d;
  logic       tx_ovr_q, tx_ovr_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= TX_IDLE;
      tx_data_q   <= 8'h00;
      pend_data_q <= 8'h00;
      pend_vld_q  <= 1'b0;
      trmt_q      <= 1'b0;
      resp_sent_q <= 1'b0;
      tx_ovr_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      tx_data_q   <= tx_data_d;
      pend_data_q <= pend_data_d;
      pend_vld_q  <= pend_vld_d;
      trmt_q      <= trmt_d;
      resp_sent_q <= resp_sent_d;
      tx_ovr_q    <= tx_ovr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      TX_IDLE: if (send_resp) state_d = TX_BUSY;
      TX_BUSY: if (tx_done && !pend_vld_q && !send_resp) state_d = TX_IDLE;
      default: state_d = TX_IDLE;
    endcase
  end

  always_comb begin
    tx_data_d   = tx_data_q;
    pend_data_d = pend_data_q;
    pend_vld_d  = pend_vld_q;
    trmt_d      = 1'b0;
    resp_sent_d = 1'b0;
    tx_ovr_d    = tx_ovr_q;
    case (state_q)
      TX_IDLE: begin
        if (send_resp) begin
          tx_data_d = resp;
          trmt_d    = 1'b1;
        end
      end
      TX_BUSY: begin
        if (tx_done) begin
          resp_sent_d = 1'b1;
          if (pend_vld_q) begin
            // Pending byte launches; a coincident request refills the freed slot.
            tx_data_d  = pend_data_q;
            trmt_d     = 1'b1;
            pend_vld_d = send_resp;
            if (send_resp) pend_data_d = resp;
          end else if (send_resp) begin
            tx_data_d = resp;
            trmt_d    = 1'b1;
          end
        end else if (send_resp) begin
          if (pend_vld_q) begin
            tx_ovr_d = 1'b1;
          end else begin
            pend_data_d = resp;
            pend_vld_d  = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  assign trmt      = trmt_q;
  assign tx_data   = tx_data_q;
  assign resp_sent = resp_sent_q;
  assign tx_ovr    = tx_ovr_q;

endmodule

// File: rtl/uart_cmd_link.sv
// Assembles two rx bytes (high first) into a held 16-bit command and forwards responses to the tx core.
// All outputs are registered; a held command stalls further rx bytes in the rx core until cleared.
module uart_cmd_link
  import link_pkg::*;
#(
  parameter int TIMEOUT_CYC = 1_000_000,
  parameter int TO_W        = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_rdy,
  input  logic [7:0]  rx_data,
  output logic        clr_rx_rdy,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic [7:0]  resp,
  input  logic        send_resp,
  output logic        resp_sent,
  output logic        trmt,
  output logic [7:0]  tx_data,
  input  logic        tx_done,
  output logic        frame_err,
  output logic        tx_ovr
);

  rx_state_t         state_q, state_d;
  logic [15:0]       cmd_q, cmd_d;
  logic              cmd_rdy_q, cmd_rdy_d;
  logic              clr_rx_q, clr_rx_d;
  logic              frame_err_q, frame_err_d;
  logic [TO_W-1:0]   timer_q, timer_d;
  logic              rx_vld;
  logic              timeout;

  // rx_rdy is still high in the cycle our clear pulse is out; don't take the same byte twice.
  assign rx_vld  = rx_rdy && !clr_rx_q;
  assign timeout = (timer_q == TO_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= WAIT_HI;
      cmd_q       <= 16'h0000;
      cmd_rdy_q   <= 1'b0;
      clr_rx_q    <= 1'b0;
      frame_err_q <= 1'b0;
      timer_q     <= '0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      cmd_rdy_q   <= cmd_rdy_d;
      clr_rx_q    <= clr_rx_d;
      frame_err_q <= frame_err_d;
      timer_q     <= timer_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      WAIT_HI: if (rx_vld) state_d = WAIT_LO;
      WAIT_LO: begin
        if (rx_vld)       state_d = HOLD;
        else if (timeout) state_d = WAIT_HI;
      end
      HOLD:    if (clr_cmd_rdy) state_d = WAIT_HI;
      default: state_d = WAIT_HI;
    endcase
  end

  always_comb begin
    cmd_d       = cmd_q;
    cmd_rdy_d   = cmd_rdy_q;
    clr_rx_d    = 1'b0;
    frame_err_d = 1'b0;
    timer_d     = timer_q;
    case (state_q)
      WAIT_HI: begin
        if (rx_vld) begin
          cmd_d[15:8] = rx_data;
          clr_rx_d    = 1'b1;
          timer_d     = '0;
        end
      end
      WAIT_LO: begin
        if (rx_vld) begin
          cmd_d[7:0] = rx_data;
          clr_rx_d   = 1'b1;
          cmd_rdy_d  = 1'b1;
        end else begin
          timer_d     = timer_q + TO_W'(1);
          frame_err_d = timeout;
        end
      end
      HOLD: if (clr_cmd_rdy) cmd_rdy_d = 1'b0;
      default: ;
    endcase
  end

  assign cmd        = cmd_q;
  assign cmd_rdy    = cmd_rdy_q;
  assign clr_rx_rdy = clr_rx_q;
  assign frame_err  = frame_err_q;

  resp_tx_q u_resp_tx_q (
    .clk       (clk),
    .rst       (rst),
    .send_resp (send_resp),
    .resp      (resp),
    .tx_done   (tx_done),
    .trmt      (trmt),
    .tx_data   (tx_data),
    .resp_sent (resp_sent),
    .tx_ovr    (tx_ovr)
  );

endmodule

// File: tb/tb_uart_cmd_link.sv
// Bench for uart_cmd_link: tx vector table, directed rx sequences, randomized traffic vs a queue model.
module tb_uart_cmd_link;
  import link_pkg::*;

  localparam int T = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_rdy;
  logic [7:0]  rx_data;
  logic        clr_rx_rdy;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic [7:0]  resp;
  logic        send_resp;
  logic        resp_sent;
  logic        trmt;
  logic [7:0]  tx_data;
  logic        tx_done;
  logic        frame_err;
  logic        tx_ovr;

  always #5 clk = ~clk;

  uart_cmd_link #(.TIMEOUT_CYC(T), .TO_W(5)) dut (
    .clk(clk), .rst(rst), .rx_rdy(rx_rdy), .rx_data(rx_data), .clr_rx_rdy(clr_rx_rdy),
    .cmd(cmd), .cmd_rdy(cmd_rdy), .clr_cmd_rdy(clr_cmd_rdy), .resp(resp),
    .send_resp(send_resp), .resp_sent(resp_sent), .trmt(trmt), .tx_data(tx_data),
    .tx_done(tx_done), .frame_err(frame_err), .tx_ovr(tx_ovr)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0, clr_cnt = 0, fe_cnt = 0, clr_cyc = 0, fe_cyc = 0, trmt_cnt = 0, rs_cnt = 0;
  bit drop_pend = 1'b0;

  typedef struct {
    logic       sr;
    logic [7:0] resp;
    logic       td;
    logic       trmt;
    logic       rs;
    logic       ovr;
    logic [7:0] txd;
  } tx_vec_t;

  tx_vec_t tv[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: sample at the falling edge, emulate the rx core clearing rx_rdy after clr_rx_rdy.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (clr_rx_rdy) begin
      clr_cnt++;
      clr_cyc   = cyc;
      drop_pend = 1'b1;
    end else if (drop_pend) begin
      rx_rdy    = 1'b0;
      drop_pend = 1'b0;
    end
    if (frame_err) begin
      fe_cnt++;
      fe_cyc = cyc;
    end
    if (trmt) trmt_cnt++;
    if (resp_sent) rs_cnt++;
  endtask

  task automatic present(input logic [7:0] b);
    rx_data = b;
    rx_rdy  = 1'b1;
  endtask

  task automatic wait_consumed(input string name);
    int n = 0;
    while (rx_rdy && n < 100) begin
      tick();
      n++;
    end
    chk({name, "_consumed"}, 32'(rx_rdy), 32'd0);
  endtask

  task automatic release_cmd();
    clr_cmd_rdy = 1'b1;
    tick();
    clr_cmd_rdy = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rx_rdy = 1'b0; rx_data = 8'h00; clr_cmd_rdy = 1'b0;
    send_resp = 1'b0; resp = 8'h00; tx_done = 1'b0;
    drop_pend = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_cmd"}, 32'(cmd), 32'd0);
    chk({name, "_cmd_rdy"}, 32'(cmd_rdy), 32'd0);
    chk({name, "_clr_rx_rdy"}, 32'(clr_rx_rdy), 32'd0);
    chk({name, "_trmt"}, 32'(trmt), 32'd0);
    chk({name, "_resp_sent"}, 32'(resp_sent), 32'd0);
    chk({name, "_tx_data"}, 32'(tx_data), 32'd0);
    chk({name, "_frame_err"}, 32'(frame_err), 32'd0);
    chk({name, "_tx_ovr"}, 32'(tx_ovr), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [7:0] txq[$];
    logic [7:0] bytes_q[$];
    logic       ovr_m, exp_trmt, exp_rs, was_busy, prev_cmd_rdy, clr_prev;
    logic [7:0] b;
    logic [15:0] exp_cmd;
    int tx_cnt, gap, clr_dly, k, c0, f0, t0, r0;

    //  sr    resp   td  | trmt rs  ovr  tx_data
    tv[0]  = '{1'b1, ACK,   1'b0, 1'b1, 1'b0, 1'b0, ACK};
    tv[1]  = '{1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, ACK};
    tv[2]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, ACK};
    tv[3]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, ACK};
    tv[4]  = '{1'b1, 8'h33, 1'b0, 1'b1, 1'b0, 1'b0, 8'h33};
    tv[5]  = '{1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0, 8'h33};
    tv[6]  = '{1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 1'b1, 8'h33};
    tv[7]  = '{1'b0, 8'hFF, 1'b1, 1'b1, 1'b1, 1'b1, 8'h11};
    tv[8]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h11};
    tv[9]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'h11};
    tv[10] = '{1'b1, 8'h44, 1'b1, 1'b1, 1'b0, 1'b1, 8'h44};
    tv[11] = '{1'b1, 8'h55, 1'b1, 1'b1, 1'b1, 1'b1, 8'h55};
    tv[12] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 8'h55};
    tv[13] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'h55};

    // Reset state, sampled while reset is held.
    rst = 1'b1;
    rx_rdy = 1'b0; rx_data = 8'h00; clr_cmd_rdy = 1'b0;
    send_resp = 1'b0; resp = 8'h00; tx_done = 1'b0;
    repeat (3) tick();
    chk_all_zero("reset");
    rst = 1'b0;
    tick();

    // Tx path vector table.
    for (int i = 0; i < 14; i++) begin
      send_resp = tv[i].sr;
      resp      = tv[i].resp;
      tx_done   = tv[i].td;
      tick();
      chk($sformatf("tx_vec%0d_trmt", i), 32'(trmt), 32'(tv[i].trmt));
      chk($sformatf("tx_vec%0d_resp_sent", i), 32'(resp_sent), 32'(tv[i].rs));
      chk($sformatf("tx_vec%0d_tx_ovr", i), 32'(tx_ovr), 32'(tv[i].ovr));
      chk($sformatf("tx_vec%0d_tx_data", i), 32'(tx_data), 32'(tv[i].txd));
    end
    send_resp = 1'b0; tx_done = 1'b0;

    // Basic command assembly and hold.
    c0 = clr_cnt;
    present(8'h47); wait_consumed("t1_hi");
    present(8'h12); wait_consumed("t1_lo");
    chk("t1_clr_count", 32'(clr_cnt - c0), 32'd2);
    chk("t1_cmd", 32'(cmd), 32'h4712);
    chk("t1_cmd_rdy", 32'(cmd_rdy), 32'd1);
    repeat (5) tick();
    chk("t1_cmd_rdy_held", 32'(cmd_rdy), 32'd1);
    release_cmd();
    chk("t1_cmd_rdy_cleared", 32'(cmd_rdy), 32'd0);

    // Byte arriving while a command is held stays pending until release.
    present(8'h34); wait_consumed("t3_hi");
    present(8'h56); wait_consumed("t3_lo");
    c0 = clr_cnt;
    present(8'h9A);
    repeat (8) tick();
    chk("t3_no_clr_in_hold", 32'(clr_cnt - c0), 32'd0);
    chk("t3_byte_pending", 32'(rx_rdy), 32'd1);
    chk("t3_cmd_held", 32'(cmd), 32'h3456);
    release_cmd();
    wait_consumed("t3_pending");
    chk("t3_pending_clr", 32'(clr_cnt - c0), 32'd1);
    chk("t3_new_hi", 32'(cmd[15:8]), 32'h9A);
    chk("t3_cmd_rdy_low", 32'(cmd_rdy), 32'd0);
    present(8'hBC); wait_consumed("t3_lo2");
    chk("t3_cmd2", 32'(cmd), 32'h9ABC);
    release_cmd();

    // Inter-byte timeout.
    f0 = fe_cnt;
    present(8'h40); wait_consumed("t2_hi");
    k = 0;
    while (fe_cnt == f0 && k < 3 * T) begin
      tick();
      k++;
    end
    chk("t2_frame_err_seen", 32'(fe_cnt - f0), 32'd1);
    chk("t2_frame_err_delay", 32'(fe_cyc - clr_cyc), 32'(T));
    repeat (T + 4) tick();
    chk("t2_frame_err_once", 32'(fe_cnt - f0), 32'd1);
    chk("t2_cmd_rdy_low", 32'(cmd_rdy), 32'd0);
    chk("t2_cmd_hi_kept", 32'(cmd[15:8]), 32'h40);
    present(8'h01); wait_consumed("t2_hi2");
    present(8'h02); wait_consumed("t2_lo2");
    chk("t2_cmd", 32'(cmd), 32'h0102);
    chk("t2_cmd_rdy", 32'(cmd_rdy), 32'd1);
    release_cmd();

    // Low byte seen on the last counted cycle beats the timeout.
    f0 = fe_cnt;
    present(8'h7E); wait_consumed("tb_hi");
    while (cyc < clr_cyc + T - 1) tick();
    present(8'hE7); wait_consumed("tb_lo");
    repeat (T + 2) tick();
    chk("tb_no_frame_err", 32'(fe_cnt - f0), 32'd0);
    chk("tb_cmd", 32'(cmd), 32'h7EE7);
    chk("tb_cmd_rdy", 32'(cmd_rdy), 32'd1);
    release_cmd();

    // Randomized traffic on both paths against queue models.
    do_reset();
    txq.delete(); bytes_q.delete();
    ovr_m = 1'b0; exp_trmt = 1'b0; exp_rs = 1'b0;
    tx_cnt = 0; gap = 0; clr_dly = 0; k = 0;
    prev_cmd_rdy = 1'b0; clr_prev = 1'b0;
    c0 = clr_cnt; f0 = fe_cnt;
    for (int i = 0; i < 3000; i++) begin
      tick();
      chk("rnd_trmt", 32'(trmt), 32'(exp_trmt));
      chk("rnd_resp_sent", 32'(resp_sent), 32'(exp_rs));
      chk("rnd_tx_ovr", 32'(tx_ovr), 32'(ovr_m));
      if (txq.size() > 0) chk("rnd_tx_data", 32'(tx_data), 32'(txq[0]));

      tx_done = 1'b0;
      if (tx_cnt > 0) begin
        tx_cnt--;
        if (tx_cnt == 0) tx_done = 1'b1;
      end
      if (trmt) tx_cnt = $urandom_range(1, 5);
      if (txq.size() == 0 && $urandom_range(0, 9) == 0) tx_done = 1'b1;
      send_resp = ($urandom_range(0, 2) == 0);
      resp      = 8'($urandom);

      exp_rs   = tx_done && (txq.size() > 0);
      was_busy = (txq.size() > 0);
      if (exp_rs) void'(txq.pop_front());
      if (send_resp) begin
        if (txq.size() < 2) txq.push_back(resp);
        else ovr_m = 1'b1;
      end
      exp_trmt = (txq.size() > 0) && (!was_busy || exp_rs);

      if (!rx_rdy && !drop_pend) begin
        if (gap > 0) gap--;
        else begin
          b = 8'($urandom);
          present(b);
          bytes_q.push_back(b);
          gap = $urandom_range(0, 3);
        end
      end

      if (clr_prev) chk("rnd_cmd_rdy_after_clr", 32'(cmd_rdy), 32'd0);
      clr_cmd_rdy = 1'b0;
      if (cmd_rdy && !prev_cmd_rdy) begin
        exp_cmd = (bytes_q.size() >= 2 * k + 2) ? {bytes_q[2 * k], bytes_q[2 * k + 1]} : 16'h0000;
        chk("rnd_cmd", 32'(cmd), 32'(exp_cmd));
        k++;
        clr_dly = $urandom_range(0, 4);
      end
      if (cmd_rdy) begin
        if (clr_dly == 0) clr_cmd_rdy = 1'b1;
        else clr_dly--;
      end
      prev_cmd_rdy = cmd_rdy;
      clr_prev     = clr_cmd_rdy;
    end
    chk("rnd_clr_count", 32'(clr_cnt - c0),
        32'(bytes_q.size() - ((rx_rdy && !drop_pend) ? 1 : 0)));
    chk("rnd_cmd_progress", 32'(k > 50), 32'd1);
    chk("rnd_no_frame_err", 32'(fe_cnt - f0), 32'd0);

    // Reset in the middle of a held command and a queued response.
    do_reset();
    present(8'h21); wait_consumed("t6_hi");
    present(8'h43); wait_consumed("t6_lo");
    send_resp = 1'b1; resp = 8'h61; tick();
    resp = 8'h62; tick();
    resp = 8'h63; tick();
    send_resp = 1'b0;
    chk("t6_pre_cmd_rdy", 32'(cmd_rdy), 32'd1);
    chk("t6_pre_tx_ovr", 32'(tx_ovr), 32'd1);
    rst = 1'b1;
    tick();
    chk_all_zero("t6_rst");
    rst = 1'b0;
    t0 = trmt_cnt; r0 = rs_cnt;
    tx_done = 1'b1; tick();
    tx_done = 1'b0;
    repeat (10) tick();
    chk("t6_no_trmt", 32'(trmt_cnt - t0), 32'd0);
    chk("t6_no_resp_sent", 32'(rs_cnt - r0), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
